dbg_cmd_ctrl: RTL and testbench

Command sequencer for the serial debug unit. It drives the line scanner's request/acknowledge handshake to fetch a one-character command, then any 32-bit hex operands. It executes the decoded command against the debug memory port and the CPU run/step controls. It sits between the scanner and the debug-side datapath and is the only block that issues `req_rx`.

---
 rtl/dbg_cmd_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_dbg_cmd_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_cmd_ctrl.sv
// Debug command sequencer: fetches a command and its hex operands, then drives memory/run/step.
// Optional CMD_TIMEOUT_EN aborts a wait that sees no ack/valid within TIMEOUT cycles.
module dbg_cmd_ctrl #(
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        req_rx,
    output logic        type_rx,
    input  logic        ack_rx,
    input  logic        flag_rx,
    input  logic [31:0] din_rx,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvld,
    output logic        run,
    output logic        step,
    output logic [31:0] res_data,
    output logic        res_vld,
    output logic        err,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ_CMD,
        S_WAIT_CMD,
        S_DECODE,
        S_REQ_ADDR,
        S_WAIT_ADDR,
        S_REQ_DATA,
        S_WAIT_DATA,
        S_MEM_RD,
        S_RD_WAIT,
        S_MEM_WR,
        S_STEP,
        S_RESP,
        S_ERR
    } state_t;

    state_t state;
    state_t state_nx;

    logic [7:0] cmd;
    logic [7:0] cmd_uc;
    logic       cmd_r;
    logic       cmd_w;
    logic       cmd_s;
    logic       cmd_g;
    logic       cmd_h;
    logic       tmo;
    logic       unused_flag;

    // Clearing bit 5 folds lower-case letters onto upper case.
    assign cmd_uc = cmd & 8'hDF;
    assign cmd_r  = (cmd_uc == 8'h52);
    assign cmd_w  = (cmd_uc == 8'h57);
    assign cmd_s  = (cmd_uc == 8'h53);
    assign cmd_g  = (cmd_uc == 8'h47);
    assign cmd_h  = (cmd_uc == 8'h48);

    assign unused_flag = flag_rx;

`ifdef CMD_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] tmo_cnt;
    logic          in_wait;

    assign in_wait = (state == S_WAIT_CMD)  ||
                     (state == S_WAIT_ADDR) ||
                     (state == S_WAIT_DATA) ||
                     (state == S_RD_WAIT);

    // Every wait state is entered from a non-wait state, so the count restarts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (in_wait) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo = in_wait && (tmo_cnt == CW'(TIMEOUT - 1));
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT;
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (en) state_nx = S_REQ_CMD;
            end
            S_REQ_CMD:  state_nx = S_WAIT_CMD;
            S_REQ_ADDR: state_nx = S_WAIT_ADDR;
            S_REQ_DATA: state_nx = S_WAIT_DATA;
            S_WAIT_CMD: begin
                if (ack_rx)   state_nx = S_DECODE;
                else if (tmo) state_nx = S_ERR;
            end
            S_DECODE: begin
                unique case (1'b1)
                    cmd_r, cmd_w: state_nx = S_REQ_ADDR;
                    cmd_s:        state_nx = S_STEP;
                    cmd_g, cmd_h: state_nx = S_IDLE;
                    default:      state_nx = S_ERR;
                endcase
            end
            S_WAIT_ADDR: begin
                if (ack_rx)   state_nx = cmd_w ? S_REQ_DATA : S_MEM_RD;
                else if (tmo) state_nx = S_ERR;
            end
            S_WAIT_DATA: begin
                if (ack_rx)   state_nx = S_MEM_WR;
                else if (tmo) state_nx = S_ERR;
            end
            S_MEM_RD: state_nx = S_RD_WAIT;
            S_RD_WAIT: begin
                if (mem_rvld) state_nx = S_RESP;
                else if (tmo) state_nx = S_ERR;
            end
            S_MEM_WR: state_nx = S_IDLE;
            S_STEP:   state_nx = S_IDLE;
            S_RESP:   state_nx = S_IDLE;
            S_ERR:    state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cmd       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            res_data  <= '0;
            run       <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_WAIT_CMD && ack_rx) begin
                cmd <= din_rx[7:0];
            end
            if (state == S_WAIT_ADDR && ack_rx) begin
                mem_addr <= din_rx;
            end
            if (state == S_WAIT_DATA && ack_rx) begin
                mem_wdata <= din_rx;
            end
            if (state == S_RD_WAIT && mem_rvld) begin
                res_data <= mem_rdata;
            end
            if (state == S_DECODE) begin
                if (cmd_g)      run <= 1'b1;
                else if (cmd_h) run <= 1'b0;
            end
        end
    end

    assign req_rx  = (state == S_REQ_CMD)  ||
                     (state == S_REQ_ADDR) ||
                     (state == S_REQ_DATA);
    assign type_rx = (state == S_REQ_ADDR) ||
                     (state == S_REQ_DATA);
    assign mem_re  = (state == S_MEM_RD);
    assign mem_we  = (state == S_MEM_WR);
    assign step    = (state == S_STEP);
    assign res_vld = (state == S_RESP);
    assign err     = (state == S_ERR);
    assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_dbg_cmd_ctrl.sv
// Bench for dbg_cmd_ctrl: vector table, reset/hold sequences, randomized commands.
// Expected timing comes from a cycle-count model of the command protocol.
module tb_dbg_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        req_rx;
    logic        type_rx;
    logic        ack_rx;
    logic        flag_rx;
    logic [31:0] din_rx;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        mem_rvld;
    logic        run;
    logic        step;
    logic [31:0] res_data;
    logic        res_vld;
    logic        err;
    logic        busy;

    always #5 clk = ~clk;

    dbg_cmd_ctrl #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_rx    (req_rx),
        .type_rx   (type_rx),
        .ack_rx    (ack_rx),
        .flag_rx   (flag_rx),
        .din_rx    (din_rx),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_rvld  (mem_rvld),
        .run       (run),
        .step      (step),
        .res_data  (res_data),
        .res_vld   (res_vld),
        .err       (err),
        .busy      (busy)
    );

    typedef struct {
        int          done;
        int          nreq;
        int          req2;
        int          types;
        int          nstep;
        int          nre;
        int          nwe;
        int          nres;
        int          nerr;
        int          t_ev;
        int          t_res;
        int          t_idle;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] res;
        logic        run;
    } obs_t;

    typedef struct {
        logic [7:0]  ch;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        int          rlat;
        int          e_nreq;
        int          e_step;
        int          e_re;
        int          e_we;
        int          e_err;
        int          e_t;
        int          e_tres;
        int          e_idle;
        logic        e_run;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic model_run = 1'b0;
    vec_t tbl[$];

    task automatic chk(input string nm, input int idx,
                       input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, got, exp);
        end
    endtask

    task automatic add(input logic [7:0] ch, input logic [31:0] a, d, rd,
                       input int rlat, nreq, stp, re, we, er, t, tres, idle,
                       input logic rn);
        vec_t v;
        v.ch = ch; v.a = a; v.d = d; v.rd = rd; v.rlat = rlat;
        v.e_nreq = nreq; v.e_step = stp; v.e_re = re; v.e_we = we;
        v.e_err = er; v.e_t = t; v.e_tres = tres; v.e_idle = idle;
        v.e_run = rn;
        tbl.push_back(v);
    endtask

    // Reference: cycle numbers counted from the IDLE cycle in which en is taken.
    task automatic model(input logic [7:0] ch, input int d, rlat,
                         input logic [31:0] a, wd, rd, output obs_t e);
        logic [7:0] u;
        e = '{default: 0};
        u = (ch >= 8'h61 && ch <= 8'h7A) ? ch - 8'h20 : ch;
        e.done = 1;
        e.nreq = 1;
        case (u)
            8'h53: begin
                e.nstep = 1; e.t_ev = 3 + d; e.t_idle = 4 + d;
            end
            8'h47: begin
                model_run = 1'b1; e.t_idle = 3 + d;
            end
            8'h48: begin
                model_run = 1'b0; e.t_idle = 3 + d;
            end
            8'h52: begin
                e.nreq = 2; e.types = 2; e.nre = 1; e.nres = 1;
                e.t_ev = 4 + 2 * d;
                e.t_res = 5 + 2 * d + rlat;
                e.t_idle = 6 + 2 * d + rlat;
                e.res = rd;
            end
            8'h57: begin
                e.nreq = 3; e.types = 6; e.nwe = 1;
                e.t_ev = 5 + 3 * d; e.t_idle = 6 + 3 * d;
                e.addr = a; e.wdata = wd;
            end
            default: begin
                e.nerr = 1; e.t_ev = 3 + d; e.t_idle = 4 + d;
            end
        endcase
        e.run = model_run;
    endtask

    task automatic run_cmd(input logic [7:0] ch, input logic [31:0] a, wd, rd,
                           input int d, rlat, input bit spur, output obs_t o);
        int          ack_at;
        int          ack_idx;
        int          rv_at;
        logic        prev_req;
        logic [31:0] ws [3];
        o = '{default: 0};
        ws[0] = {24'($urandom), ch};
        ws[1] = a;
        ws[2] = wd;
        ack_at = -1;
        ack_idx = 0;
        rv_at = -1;
        prev_req = 1'b0;
        @(negedge clk);
        en = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            en = 1'b0;
            ack_rx = 1'b0;
            mem_rvld = 1'b0;
            din_rx = $urandom;
            mem_rdata = $urandom;
            if (c == ack_at) begin
                ack_rx = 1'b1;
                din_rx = ws[ack_idx];
            end else if (spur && c == ack_at + 1) begin
                ack_rx = 1'b1;
            end
            if (c == rv_at) begin
                mem_rvld = 1'b1;
                mem_rdata = rd;
            end
            if (req_rx) begin
                if (prev_req) o.req2++;
                o.types |= int'(type_rx) << o.nreq;
                ack_idx = (o.nreq < 3) ? o.nreq : 2;
                ack_at = c + d;
                o.nreq++;
            end
            prev_req = req_rx;
            if (mem_re) begin
                o.nre++; o.t_ev = c; rv_at = c + rlat;
                if (spur) begin
                    mem_rvld = 1'b1;
                    mem_rdata = ~rd;
                end
            end
            if (mem_we) begin
                o.nwe++; o.t_ev = c;
                o.addr = mem_addr; o.wdata = mem_wdata;
            end
            if (step) begin
                o.nstep++; o.t_ev = c;
            end
            if (err) begin
                o.nerr++; o.t_ev = c;
            end
            if (res_vld) begin
                o.nres++; o.t_res = c; o.res = res_data;
            end
            if (!busy) begin
                o.t_idle = c; o.done = 1;
                break;
            end
        end
        ack_rx = 1'b0;
        mem_rvld = 1'b0;
        o.run = run;
    endtask

    task automatic compare(input string tag, input int i, input obs_t o, e);
        chk({tag, "_done"}, i, o.done, e.done);
        chk({tag, "_nreq"}, i, o.nreq, e.nreq);
        chk({tag, "_req_b2b"}, i, o.req2, 0);
        chk({tag, "_type"}, i, o.types, e.types);
        chk({tag, "_step"}, i, o.nstep, e.nstep);
        chk({tag, "_re"}, i, o.nre, e.nre);
        chk({tag, "_we"}, i, o.nwe, e.nwe);
        chk({tag, "_res"}, i, o.nres, e.nres);
        chk({tag, "_err"}, i, o.nerr, e.nerr);
        chk({tag, "_t_ev"}, i, o.t_ev, e.t_ev);
        chk({tag, "_t_idle"}, i, o.t_idle, e.t_idle);
        chk({tag, "_run"}, i, o.run, e.run);
        if (e.nwe != 0) begin
            chk({tag, "_addr"}, i, o.addr, e.addr);
            chk({tag, "_wdata"}, i, o.wdata, e.wdata);
        end
        if (e.nres != 0) begin
            chk({tag, "_rdata"}, i, o.res, e.res);
            chk({tag, "_t_res"}, i, o.t_res, e.t_res);
        end
    endtask

    initial begin
        obs_t        o;
        obs_t        e;
        logic [7:0]  pool [11];
        int          t_err;
        int          n_err;
        int          t_idle;

        rst = 1'b1; en = 1'b0; ack_rx = 1'b0; flag_rx = 1'b0;
        din_rx = '0; mem_rdata = '0; mem_rvld = 1'b0;
        #12;
        chk("reset_strobes", 0,
            {req_rx, type_rx, mem_re, mem_we, step, res_vld, err, busy, run}, 0);
        chk("reset_regs", 0, {mem_addr, mem_wdata}, 0);
        chk("reset_res", 0, res_data, 0);
        @(negedge clk);
        rst = 1'b0;

        //   ch     addr          wdata         rdata        rl req st re we er  t tres idle run
        add(8'h73, 32'h0,        32'h0,        32'h0,        1, 1, 1, 0, 0, 0, 4, 0, 5, 1'b0);
        add(8'h47, 32'h0,        32'h0,        32'h0,        1, 1, 0, 0, 0, 0, 0, 0, 4, 1'b1);
        add(8'h53, 32'h0,        32'h0,        32'h0,        1, 1, 1, 0, 0, 0, 4, 0, 5, 1'b1);
        add(8'h68, 32'h0,        32'h0,        32'h0,        1, 1, 0, 0, 0, 0, 0, 0, 4, 1'b0);
        add(8'h57, 32'h1234,     32'hDEADBEEF, 32'h0,        1, 3, 0, 0, 1, 0, 8, 0, 9, 1'b0);
        add(8'h72, 32'h10,       32'h0,        32'hCAFEF00D, 3, 2, 0, 1, 0, 0, 6, 10, 11, 1'b0);
        add(8'h5A, 32'h0,        32'h0,        32'h0,        1, 1, 0, 0, 0, 1, 4, 0, 5, 1'b0);
        add(8'h67, 32'h0,        32'h0,        32'h0,        1, 1, 0, 0, 0, 0, 0, 0, 4, 1'b1);
        add(8'h77, 32'hFFFFFFFC, 32'h80000001, 32'h0,        1, 3, 0, 0, 1, 0, 8, 0, 9, 1'b1);
        add(8'h52, 32'h0,        32'h0,        32'hFFFFFFFF, 1, 2, 0, 1, 0, 0, 6, 8, 9, 1'b1);
        add(8'h00, 32'h0,        32'h0,        32'h0,        1, 1, 0, 0, 0, 1, 4, 0, 5, 1'b1);
        add(8'h48, 32'h0,        32'h0,        32'h0,        1, 1, 0, 0, 0, 0, 0, 0, 4, 1'b0);

        foreach (tbl[i]) begin
            run_cmd(tbl[i].ch, tbl[i].a, tbl[i].d, tbl[i].rd, 1, tbl[i].rlat, 1'b0, o);
            chk("tbl_done", i, o.done, 1);
            chk("tbl_nreq", i, o.nreq, tbl[i].e_nreq);
            chk("tbl_step", i, o.nstep, tbl[i].e_step);
            chk("tbl_re", i, o.nre, tbl[i].e_re);
            chk("tbl_we", i, o.nwe, tbl[i].e_we);
            chk("tbl_err", i, o.nerr, tbl[i].e_err);
            chk("tbl_t_ev", i, o.t_ev, tbl[i].e_t);
            chk("tbl_t_idle", i, o.t_idle, tbl[i].e_idle);
            chk("tbl_run", i, o.run, tbl[i].e_run);
            if (tbl[i].e_we != 0) begin
                chk("tbl_addr", i, o.addr, tbl[i].a);
                chk("tbl_wdata", i, o.wdata, tbl[i].d);
            end
            if (tbl[i].e_re != 0) begin
                chk("tbl_rdata", i, o.res, tbl[i].rd);
                chk("tbl_t_res", i, o.t_res, tbl[i].e_tres);
            end
        end
        model_run = 1'b0;

        // Reset while waiting for read data.
        model(8'h47, 1, 1, 0, 0, 0, e);
        run_cmd(8'h47, 0, 0, 0, 1, 1, 1'b0, o);
        compare("rst_pre", 0, o, e);
        @(negedge clk); en = 1'b1;
        @(negedge clk); en = 1'b0;
        @(negedge clk); ack_rx = 1'b1; din_rx = 32'h52;
        @(negedge clk); ack_rx = 1'b0;
        @(negedge clk);
        @(negedge clk); ack_rx = 1'b1; din_rx = 32'h55;
        @(negedge clk); ack_rx = 1'b0;
        chk("rst_mem_re", 0, mem_re, 1);
        @(negedge clk);
        chk("rst_rdwait_busy", 0, busy, 1);
        chk("rst_addr_latched", 0, mem_addr, 32'h55);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_strobes", 0,
            {req_rx, type_rx, mem_re, mem_we, step, res_vld, err, busy, run}, 0);
        chk("rst_async_regs", 0, {mem_addr, mem_wdata}, 0);
        chk("rst_async_res", 0, res_data, 0);
        @(negedge clk);
        rst = 1'b0;
        mem_rvld = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_rvld = 1'b0;
        chk("rst_stray_rvld", 0, {busy, res_vld, res_data}, 0);
        model_run = 1'b0;
        model(8'h73, 1, 1, 0, 0, 0, e);
        run_cmd(8'h73, 0, 0, 0, 1, 1, 1'b0, o);
        compare("rst_post", 0, o, e);

        // Withheld ack: timeout build aborts, default build holds.
        t_err = 0; n_err = 0; t_idle = 0;
        @(negedge clk); en = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            en = 1'b0;
            if (err) begin
                n_err++; t_err = c;
            end
            if (!busy && t_idle == 0) t_idle = c;
        end
`ifdef CMD_TIMEOUT_EN
        chk("tmo_err_n", 0, n_err, 1);
        chk("tmo_err_t", 0, t_err, 18);
        chk("tmo_idle_t", 0, t_idle, 19);
`else
        chk("hold_err_n", 0, n_err, 0);
        chk("hold_busy", 0, busy, 1);
        chk("hold_idle_t", 0, t_idle, 0);
        #1 rst = 1'b1;
        #1 chk("hold_rst_busy", 0, busy, 0);
        @(negedge clk);
        rst = 1'b0;
`endif
        chk("hold_run", 0, run, 0);

        pool[0] = 8'h52; pool[1] = 8'h72; pool[2] = 8'h57; pool[3] = 8'h77;
        pool[4] = 8'h53; pool[5] = 8'h73; pool[6] = 8'h47; pool[7] = 8'h67;
        pool[8] = 8'h48; pool[9] = 8'h68; pool[10] = 8'h00;
        for (int i = 0; i < 200; i++) begin
            logic [7:0]  ch;
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] rd;
            int          d;
            int          rl;
            bit          sp;
            ch = pool[$urandom_range(0, 10)];
            if (ch == 8'h00) ch = 8'($urandom);
            a = $urandom; wd = $urandom; rd = $urandom;
            d = $urandom_range(1, 3);
            rl = $urandom_range(1, 4);
            sp = 1'($urandom_range(0, 1));
            model(ch, d, rl, a, wd, rd, e);
            run_cmd(ch, a, wd, rd, d, rl, sp, o);
            compare("rnd", i, o, e);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
